// File: rtl/demux_rr_scheduler_if.sv
// Handshake bundle for demux_rr_scheduler: one input stream and four
// 1-deep consumer channels. slave = scheduler side, master = source/consumers.
interface demux_rr_scheduler_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ch_data0;
  logic [WIDTH-1:0] ch_data1;
  logic [WIDTH-1:0] ch_data2;
  logic [WIDTH-1:0] ch_data3;
  logic [3:0]       ch_valid;
  logic [3:0]       ch_ready;

  modport slave (
    input  in_data, in_valid, ch_ready,
    output in_ready, ch_data0, ch_data1, ch_data2, ch_data3, ch_valid
  );

  modport master (
    output in_data, in_valid, ch_ready,
    input  in_ready, ch_data0, ch_data1, ch_data2, ch_data3, ch_valid
  );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Round-robin 1-to-4 demultiplexer with a 1-deep holding register per channel.
// Optional per-channel saturating load counters under DEMUX_SCHED_STATS_EN.
module demux_rr_scheduler #(
  parameter int WIDTH = 8
`ifdef DEMUX_SCHED_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  demux_rr_scheduler_if.slave bus,
  output logic [1:0] sel
`ifdef DEMUX_SCHED_STATS_EN
  , output logic [4*CNT_W-1:0] stat_cnt
`endif
);

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q, valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;

  logic [3:0] free;
  logic [1:0] gnt;
  logic [1:0] idx;
  logic       found;
  logic       xfer;

  // A channel draining this cycle counts as free, so a full-throughput
  // stream can refill the same register without a bubble.
  always_comb begin
    free  = ~valid_q | bus.ch_ready;
    gnt   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && free[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign bus.in_ready = enable && (|free);
  assign xfer         = bus.in_valid && bus.in_ready;

  always_comb begin
    valid_d = valid_q & ~bus.ch_ready;
    data_d  = data_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    if (xfer) begin
      valid_d[gnt] = 1'b1;
      data_d[gnt]  = bus.in_data;
      ptr_d        = gnt + 2'd1;
      sel_d        = gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 4'b0000;
      data_q  <= '{default: '0};
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.ch_valid = valid_q;
  assign bus.ch_data0 = data_q[0];
  assign bus.ch_data1 = data_q[1];
  assign bus.ch_data2 = data_q[2];
  assign bus.ch_data3 = data_q[3];
  assign sel          = sel_q;

`ifdef DEMUX_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) cnt_d[gnt] = sat_inc(cnt_q[gnt]);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < 4; i++) stat_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler: reset, rotation, stall skipping,
// full/refill, enable hold-off, mid-flight reset and optional saturating stats.
module tb_demux_rr_scheduler;

  localparam int WIDTH = 8;
`ifdef DEMUX_SCHED_STATS_EN
  localparam int CNT_W = 4;
  logic [4*CNT_W-1:0] stat_cnt;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] sel;
  int         checks   = 0;
  int         failures = 0;

  demux_rr_scheduler_if #(.WIDTH(WIDTH)) bus ();

  demux_rr_scheduler #(
    .WIDTH(WIDTH)
`ifdef DEMUX_SCHED_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus),
    .sel    (sel)
`ifdef DEMUX_SCHED_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.ch_ready = 4'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.ch_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%h exp=0", bus.ch_valid); end
    checks++; if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.ch_data0 !== 8'h00) begin failures++; $display("FAIL reset_data0 got=%h exp=00", bus.ch_data0); end
  endtask

  task automatic test_stream();
    logic [1:0] exp_sel;
    bus.ch_ready = 4'hF; bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'hA0 + 8'(i);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready w%0d got=%b exp=1", i, bus.in_ready); end
      tick();
      exp_sel = 2'(i);
      checks++; if (sel !== exp_sel) begin failures++; $display("FAIL stream_sel w%0d got=%0d exp=%0d", i, sel, exp_sel); end
      if (i == 0) begin
        checks++; if (bus.ch_data0 !== 8'hA0) begin failures++; $display("FAIL stream_data0_first got=%h exp=A0", bus.ch_data0); end
      end
      if (i == 4) begin
        checks++; if (bus.ch_data0 !== 8'hA4) begin failures++; $display("FAIL stream_data0_second got=%h exp=A4", bus.ch_data0); end
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.ch_valid !== 4'b0000) begin failures++; $display("FAIL stream_drained got=%h exp=0", bus.ch_valid); end
  endtask

  task automatic test_stall_skip();
    logic [1:0] exp_sel [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0};
    bus.ch_ready = 4'b1011; bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'hB0 + 8'(i);
      tick();
      checks++; if (sel !== exp_sel[i]) begin failures++; $display("FAIL stall_sel w%0d got=%0d exp=%0d", i, sel, exp_sel[i]); end
    end
    checks++; if (bus.ch_data2 !== 8'hB2) begin failures++; $display("FAIL stall_hold_data2 got=%h exp=B2", bus.ch_data2); end
    checks++; if (bus.ch_valid[2] !== 1'b1) begin failures++; $display("FAIL stall_hold_valid2 got=%b exp=1", bus.ch_valid[2]); end
    bus.in_valid = 1'b0; bus.ch_ready = 4'hF;
    tick();
    checks++; if (bus.ch_valid !== 4'b0000) begin failures++; $display("FAIL stall_release got=%h exp=0", bus.ch_valid); end
  endtask

  task automatic test_full_refill();
    logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    bus.ch_ready = 4'h0; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'hC0 + 8'(i);
      tick();
      checks++; if (sel !== exp_sel[i]) begin failures++; $display("FAIL full_sel w%0d got=%0d exp=%0d", i, sel, exp_sel[i]); end
    end
    bus.in_data = 8'h55;
    #1;
    checks++; if (bus.ch_valid !== 4'hF) begin failures++; $display("FAIL full_valid got=%h exp=F", bus.ch_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (sel !== 2'd0) begin failures++; $display("FAIL full_sel_hold got=%0d exp=0", sel); end
    checks++; if (bus.ch_data1 !== 8'hC0) begin failures++; $display("FAIL full_data1_hold got=%h exp=C0", bus.ch_data1); end
    bus.ch_ready = 4'b0010;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL refill_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.ch_valid !== 4'hF) begin failures++; $display("FAIL refill_valid got=%h exp=F", bus.ch_valid); end
    checks++; if (bus.ch_data1 !== 8'h55) begin failures++; $display("FAIL refill_data1 got=%h exp=55", bus.ch_data1); end
    checks++; if (sel !== 2'd1) begin failures++; $display("FAIL refill_sel got=%0d exp=1", sel); end
    bus.in_valid = 1'b0; bus.ch_ready = 4'h0;
    tick();
  endtask

  task automatic test_enable_and_reset();
    enable = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.ch_ready = 4'hF;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL en_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.ch_valid !== 4'h0) begin failures++; $display("FAIL en_drain got=%h exp=0", bus.ch_valid); end
    checks++; if (sel !== 2'd1) begin failures++; $display("FAIL en_sel_hold got=%0d exp=1", sel); end
    tick();
    checks++; if (bus.ch_valid !== 4'h0) begin failures++; $display("FAIL en_no_load got=%h exp=0", bus.ch_valid); end
    enable = 1'b1; bus.in_data = 8'h78;
    tick();
    checks++; if (sel !== 2'd2) begin failures++; $display("FAIL en_ptr_hold got=%0d exp=2", sel); end
    checks++; if (bus.ch_data2 !== 8'h78) begin failures++; $display("FAIL en_data2 got=%h exp=78", bus.ch_data2); end
    bus.ch_ready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'h79 + 8'(i);
      tick();
    end
    checks++; if (bus.ch_valid !== 4'hF) begin failures++; $display("FAIL rst_prefill got=%h exp=F", bus.ch_valid); end
    checks++; if (bus.ch_data1 !== 8'h7B) begin failures++; $display("FAIL rst_prefill_data1 got=%h exp=7B", bus.ch_data1); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.ch_valid !== 4'h0) begin failures++; $display("FAIL rst_mid_valid got=%h exp=0", bus.ch_valid); end
    checks++; if (sel !== 2'd0) begin failures++; $display("FAIL rst_mid_sel got=%0d exp=0", sel); end
    checks++; if ({bus.ch_data0, bus.ch_data1, bus.ch_data2, bus.ch_data3} !== 32'h0) begin
      failures++; $display("FAIL rst_mid_data got=%h exp=0", {bus.ch_data0, bus.ch_data1, bus.ch_data2, bus.ch_data3});
    end
    bus.in_data = 8'h9A;
    tick();
    checks++; if (bus.ch_valid !== 4'b0001) begin failures++; $display("FAIL rst_ptr_valid got=%h exp=1", bus.ch_valid); end
    checks++; if (bus.ch_data0 !== 8'h9A) begin failures++; $display("FAIL rst_ptr_data0 got=%h exp=9A", bus.ch_data0); end
    bus.in_valid = 1'b0;
    tick();
  endtask

`ifdef DEMUX_SCHED_STATS_EN
  task automatic test_stats();
    rst = 1'b1; bus.in_valid = 1'b0; bus.ch_ready = 4'h0;
    tick();
    rst = 1'b0;
    checks++; if (stat_cnt !== 16'h0000) begin failures++; $display("FAIL stats_reset got=%h exp=0000", stat_cnt); end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'hD0 + 8'(i);
      tick();
    end
    bus.ch_ready = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 8'hE0 + 8'(i);
      tick();
    end
    checks++; if (stat_cnt !== 16'h111F) begin failures++; $display("FAIL stats_sat got=%h exp=111F", stat_cnt); end
    bus.in_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall_skip();
    test_full_refill();
    test_enable_and_reset();
`ifdef DEMUX_SCHED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
